pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- SCREEN_H, 480, visible lines
- PAD_H, 48, paddle height (px)
- PAD_W, 8, paddle width (px)
- BALL_SZ, 8, ball side (px)
- P1_X, 16, paddle 1 left x
- P2_X, 616, paddle 2 left x
- PAD_STEP, 4, paddle px per frame
- BALL_STEP, 2, ball px per frame per axis
- HOLD_FR, 60, frames frozen after a point
- WIN_SCORE, 9, winning score (<=15)

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock_50MHz, in, 1, sole clock
- rst, in, 1, synchronous active-high reset
- frame_tick, in, 1, one-cycle pulse per frame (vertical blank)
- start, in, 1, level, active-high
- p1_up, in, 1, level
- p1_dn, in, 1, level
- p2_up, in, 1, level
- p2_dn, in, 1, level
- rnd, in, 2, random bits from random generator
- x1, out, 10, paddle 1 top-left x
- y1, out, 10, paddle 1 top-left y
- x2, out, 10, paddle 2 top-left x
- y2, out, 10, paddle 2 top-left y
- xb, out, 10, ball top-left x
- yb, out, 10, ball top-left y
- score1, out, 4, player 1 score
- score2, out, 4, player 2 score
- playing, out, 1, high in PLAY
- point, out, 1, one-cycle pulse when a score increments

REQ-003 There SHALL be one clock (clock_50MHz); reset SHALL be synchronous and active-high (rst).

Function
REQ-004 FSM states SHALL be IDLE, SERVE, PLAY, SCORED, GAMEOVER.
REQ-005 start SHALL be edge-detected (registered); only a 0->1 edge acts, and only in IDLE or GAMEOVER; elsewhere it is ignored.
REQ-006 IDLE: on start edge -> SERVE. GAMEOVER: on start edge, clear scores -> SERVE.
REQ-007 SERVE: on entry ball is centred, xb=316, yb=236. Directions are latched from rnd: rnd[0]=1 right else left; rnd[1]=1 down else up. On next frame_tick -> PLAY.
REQ-008 Position updates SHALL occur only on cycles with frame_tick=1 in PLAY; new values SHALL be visible on outputs the following cycle (latency 1).
REQ-009 Paddle motion: up XOR dn moves y by PAD_STEP (up decrements). Both or neither pressed = no move. Result SHALL clamp to [0, SCREEN_H-PAD_H] (0..432 default); no wrap-around.
REQ-010 Ball vertical motion:
- next y <= 0: yb=0, dy flips.
- next y >= SCREEN_H-BALL_SZ: yb=472, dy flips.
- Arithmetic SHALL use signed 11-bit intermediates to avoid underflow.
REQ-011 Paddle 1 hit (moving left): next x <= P1_X+PAD_W and yb+BALL_SZ > y1 and yb < y1+PAD_H. Response: xb=P1_X+PAD_W, dx=right. Paddle 2 hit mirrors this with next x+BALL_SZ >= P2_X, giving xb=P2_X-BALL_SZ.
REQ-012 Collision tests SHALL use paddle positions registered before the current tick (pre-update values).
REQ-013 Miss: next x <= 0 gives score2+1; next x >= 640-BALL_SZ gives score1+1. Ball freezes at the clamped edge, point pulses one cycle, state -> SCORED. Hit takes priority over miss on the same tick.
REQ-014 SCORED: count HOLD_FR frame_ticks. Then, if either score == WIN_SCORE -> GAMEOVER, else -> SERVE. Scores SHALL never exceed WIN_SCORE.
REQ-015 x1=P1_X and x2=P2_X SHALL be constant. Paddles SHALL be frozen outside PLAY.
REQ-016 playing=1 only in PLAY.

Reset
REQ-017 rst SHALL take priority over all inputs, including frame_tick and start in the same cycle.
REQ-018 rst SHALL force, the next cycle:
- state=IDLE
- y1=y2=216
- xb=316, yb=236
- dx=right, dy=down
- scores=0, point=0, playing=0
- hold counter=0, start edge register=0
REQ-019 rst asserted mid-PLAY or mid-SCORED SHALL abort the game with no point pulse.

Verification
REQ-020 Reset, then start edge, then frame_tick with rnd=2'b11 -> PLAY. After one more tick: xb=318, yb=238, playing=1.
REQ-021 p1_up held 60 ticks from y1=216 -> y1 stops at 0. p1_up and p1_dn together -> y1 unchanged.
REQ-022 Ball moving left at yb=216 with y1=216, next x reaching 24 -> xb=24, dx right, scores unchanged.
REQ-023 Ball moving left with y1=0, yb=300 -> after reaching x<=0: score2=1, one-cycle point pulse, SCORED. After 60 ticks -> SERVE.
REQ-024 score1=8 and player 1 scores again -> score1=9, GAMEOVER after hold. A start edge then gives scores=0 and SERVE.
REQ-025 rst pulsed in PLAY in the same cycle as frame_tick -> all reset values of REQ-018 next cycle, no point pulse.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-state controller for a two-player Pong.
//
// Holds paddle and ball positions, scores and the game FSM
// (IDLE -> SERVE -> PLAY -> SCORED -> SERVE/GAMEOVER). All motion is
// advanced on frame_tick while in PLAY, and the new values appear on the
// outputs one cycle later.
//
// Ports:
//   clock_50MHz          sole clock
//   rst                  synchronous active-high reset
//   frame_tick           one-cycle pulse per frame
//   start                level; only its rising edge acts, in IDLE/GAMEOVER
//   p1_up/p1_dn          paddle 1 controls (levels)
//   p2_up/p2_dn          paddle 2 controls (levels)
//   rnd[1:0]             serve direction: [0]=1 right, [1]=1 down
//   x1,y1 / x2,y2        paddle top-left corners (x is constant)
//   xb,yb                ball top-left corner
//   score1/score2        player scores, saturate at WIN_SCORE
//   playing              high while in PLAY
//   point                one-cycle pulse when a score increments
module pong_game_ctrl #(
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned PAD_H     = 48,
    parameter int unsigned PAD_W     = 8,
    parameter int unsigned BALL_SZ   = 8,
    parameter int unsigned P1_X      = 16,
    parameter int unsigned P2_X      = 616,
    parameter int unsigned PAD_STEP  = 4,
    parameter int unsigned BALL_STEP = 2,
    parameter int unsigned HOLD_FR   = 60,
    parameter int unsigned WIN_SCORE = 9
) (
    input  logic       clock_50MHz,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic [1:0] rnd,
    output logic [9:0] x1,
    output logic [9:0] y1,
    output logic [9:0] x2,
    output logic [9:0] y2,
    output logic [9:0] xb,
    output logic [9:0] yb,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       playing,
    output logic       point
);

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned HOLD_W   = $clog2(HOLD_FR + 1);

    // Signed 11-bit constants so that "next position" arithmetic can go
    // below zero without wrapping.
    localparam logic signed [10:0] PAD_Y_MAX   = 11'(SCREEN_H - PAD_H);
    localparam logic signed [10:0] BALL_Y_MAX  = 11'(SCREEN_H - BALL_SZ);
    localparam logic signed [10:0] BALL_X_MAX  = 11'(SCREEN_W - BALL_SZ);
    localparam logic signed [10:0] P1_FACE     = 11'(P1_X + PAD_W);
    localparam logic signed [10:0] P2_FACE     = 11'(P2_X);
    localparam logic signed [10:0] P2_BALL_X   = 11'(P2_X - BALL_SZ);
    localparam logic signed [10:0] PAD_H_S     = 11'(PAD_H);
    localparam logic signed [10:0] BALL_SZ_S   = 11'(BALL_SZ);
    localparam logic signed [10:0] PAD_STEP_S  = 11'(PAD_STEP);
    localparam logic signed [10:0] BALL_STEP_S = 11'(BALL_STEP);

    localparam logic [9:0] XB_CTR  = 10'((SCREEN_W - BALL_SZ) / 2);
    localparam logic [9:0] YB_CTR  = 10'((SCREEN_H - BALL_SZ) / 2);
    localparam logic [9:0] PAD_CTR = 10'((SCREEN_H - PAD_H) / 2);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FR - 1);
    localparam logic [3:0]        WIN_S     = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        StIdle,
        StServe,
        StPlay,
        StScored,
        StGameOver
    } state_t;

    state_t              state;
    logic                start_q;
    logic                dx;        // 1 = moving right
    logic                dy;        // 1 = moving down
    logic [HOLD_W-1:0]   hold_cnt;

    logic                start_edge;
    logic signed [10:0]  xb_s, yb_s, y1_s, y2_s;
    logic signed [10:0]  nx, ny;
    logic [9:0]          yb_n;
    logic                dy_n;
    logic                hit1, hit2, miss_left, miss_right;
    logic [9:0]          y1_n, y2_n;

    assign x1 = 10'(P1_X);
    assign x2 = 10'(P2_X);

    assign start_edge = start & ~start_q;

    function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up,
                                            input logic dn);
        logic signed [10:0] t;
        t = $signed({1'b0, y});
        if (up && !dn) begin
            t = t - PAD_STEP_S;
        end else if (dn && !up) begin
            t = t + PAD_STEP_S;
        end
        if (t < 11'sd0) begin
            t = 11'sd0;
        end else if (t > PAD_Y_MAX) begin
            t = PAD_Y_MAX;
        end
        return t[9:0];
    endfunction

    always_comb begin
        xb_s = $signed({1'b0, xb});
        yb_s = $signed({1'b0, yb});
        y1_s = $signed({1'b0, y1});
        y2_s = $signed({1'b0, y2});

        nx = dx ? xb_s + BALL_STEP_S : xb_s - BALL_STEP_S;
        ny = dy ? yb_s + BALL_STEP_S : yb_s - BALL_STEP_S;

        yb_n = ny[9:0];
        dy_n = dy;
        if (ny <= 11'sd0) begin
            yb_n = '0;
            dy_n = ~dy;
        end else if (ny >= BALL_Y_MAX) begin
            yb_n = BALL_Y_MAX[9:0];
            dy_n = ~dy;
        end

        // Collision uses the ball's current y and the paddles' pre-update y.
        hit1 = !dx && (nx <= P1_FACE) &&
               (yb_s + BALL_SZ_S > y1_s) && (yb_s < y1_s + PAD_H_S);
        hit2 = dx && (nx + BALL_SZ_S >= P2_FACE) &&
               (yb_s + BALL_SZ_S > y2_s) && (yb_s < y2_s + PAD_H_S);
        miss_left  = !dx && (nx <= 11'sd0);
        miss_right = dx && (nx >= BALL_X_MAX);

        y1_n = pad_next(y1, p1_up, p1_dn);
        y2_n = pad_next(y2, p2_up, p2_dn);
    end

    always_ff @(posedge clock_50MHz) begin
        if (rst) begin
            state    <= StIdle;
            start_q  <= 1'b0;
            y1       <= PAD_CTR;
            y2       <= PAD_CTR;
            xb       <= XB_CTR;
            yb       <= YB_CTR;
            dx       <= 1'b1;
            dy       <= 1'b1;
            score1   <= '0;
            score2   <= '0;
            hold_cnt <= '0;
            playing  <= 1'b0;
            point    <= 1'b0;
        end else begin
            start_q <= start;
            point   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start_edge) begin
                        state <= StServe;
                        xb    <= XB_CTR;
                        yb    <= YB_CTR;
                    end
                end
                StServe: begin
                    // Keep sampling rnd; the value on the leaving tick wins.
                    dx <= rnd[0];
                    dy <= rnd[1];
                    if (frame_tick) begin
                        state   <= StPlay;
                        playing <= 1'b1;
                    end
                end
                StPlay: begin
                    if (frame_tick) begin
                        y1 <= y1_n;
                        y2 <= y2_n;
                        yb <= yb_n;
                        dy <= dy_n;
                        if (hit1) begin
                            xb <= P1_FACE[9:0];
                            dx <= 1'b1;
                        end else if (hit2) begin
                            xb <= P2_BALL_X[9:0];
                            dx <= 1'b0;
                        end else if (miss_left) begin
                            xb       <= '0;
                            score2   <= (score2 < WIN_S) ? score2 + 4'd1 : score2;
                            point    <= 1'b1;
                            state    <= StScored;
                            playing  <= 1'b0;
                            hold_cnt <= '0;
                        end else if (miss_right) begin
                            xb       <= BALL_X_MAX[9:0];
                            score1   <= (score1 < WIN_S) ? score1 + 4'd1 : score1;
                            point    <= 1'b1;
                            state    <= StScored;
                            playing  <= 1'b0;
                            hold_cnt <= '0;
                        end else begin
                            xb <= nx[9:0];
                        end
                    end
                end
                StScored: begin
                    if (frame_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            if (score1 == WIN_S || score2 == WIN_S) begin
                                state <= StGameOver;
                            end else begin
                                state <= StServe;
                                xb    <= XB_CTR;
                                yb    <= YB_CTR;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                StGameOver: begin
                    if (start_edge) begin
                        score1 <= '0;
                        score2 <= '0;
                        state  <= StServe;
                        xb     <= XB_CTR;
                        yb     <= YB_CTR;
                    end
                end
                default: begin
                    state   <= StIdle;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: a table of hand-computed vectors, directed
// sequences for paddle clamping, hits, misses, hold and game over, and a long
// randomized run, all compared every cycle against a behavioural model.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, frame_tick, start, p1_up, p1_dn, p2_up, p2_dn;
    logic [1:0] rnd;
    logic [9:0] x1, y1, x2, y2, xb, yb;
    logic [3:0] score1, score2;
    logic       playing, point;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clock_50MHz(clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .rnd        (rnd),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .xb         (xb),
        .yb         (yb),
        .score1     (score1),
        .score2     (score2),
        .playing    (playing),
        .point      (point)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_SCORED = 3, M_OVER = 4;
    int m_phase = 0, m_y1 = 0, m_y2 = 0, m_xb = 0, m_yb = 0, m_dx = 1, m_dy = 1;
    int m_s1 = 0, m_s2 = 0, m_hold = 0, m_point = 0, m_playing = 0;
    bit m_start_prev = 0;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int pad_move(input logic up, input logic dn);
        if (up && !dn) return -4;
        if (dn && !up) return 4;
        return 0;
    endfunction

    function automatic bit overlaps(input int ball_y, input int pad_y);
        return (ball_y + 8 > pad_y) && (ball_y < pad_y + 48);
    endfunction

    task automatic model_centre();
        m_xb = 316;
        m_yb = 236;
    endtask

    task automatic model_frame();
        int nx, ny, oy1, oy2, oyb;
        oy1 = m_y1; oy2 = m_y2; oyb = m_yb;
        m_y1 = clamp(m_y1 + pad_move(p1_up, p1_dn), 0, 432);
        m_y2 = clamp(m_y2 + pad_move(p2_up, p2_dn), 0, 432);
        nx = m_xb + 2 * m_dx;
        ny = m_yb + 2 * m_dy;
        if (ny <= 0) begin
            m_yb = 0; m_dy = -m_dy;
        end else if (ny >= 472) begin
            m_yb = 472; m_dy = -m_dy;
        end else begin
            m_yb = ny;
        end
        if (m_dx < 0 && nx <= 24 && overlaps(oyb, oy1)) begin
            m_xb = 24; m_dx = 1;
        end else if (m_dx > 0 && nx + 8 >= 616 && overlaps(oyb, oy2)) begin
            m_xb = 608; m_dx = -1;
        end else if (m_dx < 0 && nx <= 0) begin
            m_xb = 0; m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9;
            m_point = 1; m_phase = M_SCORED; m_hold = 0;
        end else if (m_dx > 0 && nx >= 632) begin
            m_xb = 632; m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9;
            m_point = 1; m_phase = M_SCORED; m_hold = 0;
        end else begin
            m_xb = nx;
        end
    endtask

    task automatic model_step();
        bit edge_seen;
        if (rst) begin
            m_phase = M_IDLE; m_y1 = 216; m_y2 = 216; model_centre();
            m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_hold = 0;
            m_point = 0; m_start_prev = 0;
        end else begin
            edge_seen = start && !m_start_prev;
            m_start_prev = start;
            m_point = 0;
            case (m_phase)
                M_IDLE: if (edge_seen) begin m_phase = M_SERVE; model_centre(); end
                M_SERVE: begin
                    m_dx = rnd[0] ? 1 : -1;
                    m_dy = rnd[1] ? 1 : -1;
                    if (frame_tick) m_phase = M_PLAY;
                end
                M_PLAY: if (frame_tick) model_frame();
                M_SCORED: if (frame_tick) begin
                    m_hold++;
                    if (m_hold == 60) begin
                        m_hold = 0;
                        if (m_s1 == 9 || m_s2 == 9) m_phase = M_OVER;
                        else begin m_phase = M_SERVE; model_centre(); end
                    end
                end
                default: if (edge_seen) begin
                    m_s1 = 0; m_s2 = 0; m_phase = M_SERVE; model_centre();
                end
            endcase
        end
        m_playing = (m_phase == M_PLAY) ? 1 : 0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h required %h", name, cyc, got, exp);
        end
    endtask

    task automatic check_model();
        check("model", {x1, x2, y1, y2, xb, yb, score1, score2, playing, point},
              {10'd16, 10'd616, 10'(m_y1), 10'(m_y2), 10'(m_xb), 10'(m_yb),
               4'(m_s1), 4'(m_s2), 1'(m_playing), 1'(m_point)});
    endtask

    task automatic cycle(input logic r, input logic s, input logic t,
                         input logic [1:0] rn, input logic [3:0] pads);
        rst = r; start = s; frame_tick = t; rnd = rn;
        {p1_up, p1_dn, p2_up, p2_dn} = pads;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    typedef struct {
        logic       r, s, t;
        logic [1:0] rn;
        logic [3:0] pads;  // {p1_up, p1_dn, p2_up, p2_dn}
        int         xb, yb, y1, y2, s1, s2;
        logic       pl, pt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        logic       st;
        logic [3:0] pads;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 316, 236, 216, 216, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0000, 316, 236, 216, 216, 0, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'b11, 4'b0000, 316, 236, 216, 216, 0, 0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'b11, 4'b0000, 318, 238, 216, 216, 0, 0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 318, 238, 216, 216, 0, 0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'b00, 4'b1000, 320, 240, 212, 216, 0, 0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b00, 4'b1100, 322, 242, 212, 216, 0, 0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'b00, 4'b0001, 324, 244, 212, 220, 0, 0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 326, 246, 212, 220, 0, 0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 326, 246, 212, 220, 0, 0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 2'b00, 4'b1000, 316, 236, 216, 216, 0, 0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 316, 236, 216, 216, 0, 0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; frame_tick = 1'b0; rnd = 2'b00;
        {p1_up, p1_dn, p2_up, p2_dn} = 4'b0000;

        // Table vectors: serve, first moves, ignored start edge, reset mid-play.
        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].s, vecs[i].t, vecs[i].rn, vecs[i].pads);
            check($sformatf("vec%0d", i), {xb, yb, y1, y2, score1, score2, playing, point},
                  {10'(vecs[i].xb), 10'(vecs[i].yb), 10'(vecs[i].y1), 10'(vecs[i].y2),
                   4'(vecs[i].s1), 4'(vecs[i].s2), vecs[i].pl, vecs[i].pt});
        end

        // Paddle clamp at top, opposite buttons cancel.
        cycle(1, 0, 0, 2'b11, 4'b0000);
        cycle(0, 1, 0, 2'b11, 4'b0000);
        cycle(0, 0, 1, 2'b11, 4'b0000);
        for (int i = 0; i < 60; i++) cycle(0, 0, 1, 2'b11, 4'b1000);
        check("p1_clamp_top", y1, 10'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 2'b11, 4'b0100);
        check("p1_down3", y1, 10'd12);
        cycle(0, 0, 1, 2'b11, 4'b1100);
        check("p1_both", y1, 10'd12);

        // Paddle 1 hit: ball served left/up, paddle moved up to y=36.
        cycle(1, 0, 0, 2'b00, 4'b0000);
        cycle(0, 1, 0, 2'b00, 4'b0000);
        cycle(0, 0, 1, 2'b00, 4'b0000);
        for (int i = 0; i < 45; i++) cycle(0, 0, 1, 2'b00, 4'b1000);
        n = 0;
        while (xb != 10'd24 && n < 300) begin cycle(0, 0, 1, 2'b00, 4'b0000); n++; end
        check("hit1_pos", {xb, y1, score1, score2, playing}, {10'd24, 10'd36, 4'd0, 4'd0, 1'b1});
        cycle(0, 0, 1, 2'b00, 4'b0000);
        check("hit1_rebound", xb, 10'd26);

        // Paddle 1 at top misses: score2, point pulse, 60-tick hold, serve.
        cycle(1, 0, 0, 2'b10, 4'b0000);
        cycle(0, 1, 0, 2'b10, 4'b0000);
        n = 0;
        while (point !== 1'b1 && n < 500) begin cycle(0, 0, 1, 2'b10, 4'b1000); n++; end
        check("miss_left", {score2, score1, xb, playing, point, y1},
              {4'd1, 4'd0, 10'd0, 1'b0, 1'b1, 10'd0});
        cycle(0, 0, 0, 2'b10, 4'b0000);
        check("point_one_cycle", point, 1'b0);
        for (int i = 0; i < 59; i++) cycle(0, 0, 1, 2'b10, 4'b0000);
        check("hold_59", {xb, playing}, {10'd0, 1'b0});
        cycle(0, 0, 1, 2'b10, 4'b0000);
        check("hold_60_serve", {xb, yb, playing}, {10'd316, 10'd236, 1'b0});
        cycle(0, 0, 1, 2'b10, 4'b0000);
        check("serve_to_play", playing, 1'b1);

        // Player 1 wins 9-0 with paddle 2 parked at the top.
        cycle(1, 0, 0, 2'b11, 4'b0000);
        cycle(0, 1, 0, 2'b11, 4'b0000);
        n = 0;
        while (score1 != 4'd9 && n < 4000) begin cycle(0, 0, 1, 2'b11, 4'b0010); n++; end
        check("win_point", {score1, score2, point, xb}, {4'd9, 4'd0, 1'b1, 10'd632});
        for (int i = 0; i < 65; i++) cycle(0, 0, 1, 2'b11, 4'b0010);
        check("gameover_frozen", {score1, playing, xb}, {4'd9, 1'b0, 10'd632});
        cycle(0, 1, 0, 2'b11, 4'b0000);
        check("restart", {score1, score2, xb, playing}, {4'd0, 4'd0, 10'd316, 1'b0});
        cycle(0, 1, 1, 2'b11, 4'b0000);
        check("restart_play", playing, 1'b1);

        // Randomized run against the model.
        st = 1'b0;
        pads = 4'b0000;
        cycle(1, 0, 0, 2'b00, 4'b0000);
        for (int i = 0; i < 30000 && fails < 20; i++) begin
            if ($urandom_range(0, 15) == 0) pads = 4'($urandom);
            if ($urandom_range(0, 63) == 0) st = ~st;
            cycle($urandom_range(0, 2999) == 0, st, $urandom_range(0, 3) != 0,
                  2'($urandom), pads);
        end

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
